dm_load_unit: RTL and testbench

Read-side companion to the store byte-enable path: turns a MEM-stage load (lw/lh/lhu/lb/lbu) into a word read on the data-memory request/acknowledge port. It stalls the pipeline until the word returns, then extracts the addressed byte or halfword with sign or zero extension. It sits between the MEM stage and the data memory, parallel to the store path, and feeds the MEM/WB register.

---
 rtl/dm_load_unit_if.sv | 33 +++
 rtl/dm_load_unit.sv | 133 +++++++++++++
 tb/tb_dm_load_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dm_load_unit_if.sv
//------------------------------------------------------------------------------
// Module  : dm_load_unit_if
// Brief   : MEM-stage load and data-memory read port bundle for dm_load_unit.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dm_load_unit_if;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [2:0]  ld_op;
    logic        ld_stall;
    logic        misalign;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        bus_err;

    modport master (
        input  ld_valid, ld_addr, ld_op, mem_rdata, mem_ack,
        output ld_stall, misalign, mem_req, mem_addr, rd_data, rd_valid, bus_err
    );

    modport slave (
        output ld_valid, ld_addr, ld_op, mem_rdata, mem_ack,
        input  ld_stall, misalign, mem_req, mem_addr, rd_data, rd_valid, bus_err
    );
endinterface

`default_nettype wire

// File: rtl/dm_load_unit.sv
//------------------------------------------------------------------------------
// Module  : dm_load_unit
// Brief   : Load path: word read over req/ack, stall until data, byte/half extract.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dm_load_unit #(
    parameter int ACK_TIMEOUT = 255
) (
    input  wire logic         clk,
    input  wire logic         reset,
    dm_load_unit_if.master    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] C_CNT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr;
    logic [2:0]  r_op;
    logic [1:0]  r_lane;
    logic        r_req;
    logic [31:0] r_data;
    logic        r_valid;
    logic        r_err;

    logic        w_misalign;
    logic        w_accept;
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [31:0] w_ext;

    // Ops 5..7 fall into the word case, so only lw-like ops need a full 4-byte alignment.
    always_comb begin
        w_misalign = 1'b0;
        if (bus.ld_valid && r_state == S_IDLE) begin
            case (bus.ld_op)
                3'd1, 3'd2: w_misalign = bus.ld_addr[0];
                3'd3, 3'd4: w_misalign = 1'b0;
                default:    w_misalign = (bus.ld_addr[1:0] != 2'b00);
            endcase
        end
    end

    assign w_accept = (r_state == S_IDLE) && bus.ld_valid && !w_misalign;

    always_comb begin
        w_half = r_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_lane)
            2'd0:    w_byte = bus.mem_rdata[7:0];
            2'd1:    w_byte = bus.mem_rdata[15:8];
            2'd2:    w_byte = bus.mem_rdata[23:16];
            default: w_byte = bus.mem_rdata[31:24];
        endcase
        case (r_op)
            3'd1:    w_ext = {16'h0000, w_half};
            3'd2:    w_ext = {{16{w_half[15]}}, w_half};
            3'd3:    w_ext = {24'h000000, w_byte};
            3'd4:    w_ext = {{24{w_byte[7]}}, w_byte};
            default: w_ext = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_addr  <= 32'd0;
            r_op    <= 3'd0;
            r_lane  <= 2'd0;
            r_req   <= 1'b0;
            r_data  <= 32'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= {bus.ld_addr[31:2], 2'b00};
                        r_op    <= bus.ld_op;
                        r_lane  <= bus.ld_addr[1:0];
                        r_cnt   <= 8'd0;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    // An ack in the final allowed cycle still wins over the timeout.
                    if (bus.mem_ack) begin
                        r_data  <= w_ext;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_data  <= 32'd0;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.misalign = w_misalign;
    assign bus.ld_stall = w_accept || (r_state == S_REQ);
    assign bus.mem_req  = r_req;
    assign bus.mem_addr = r_addr;
    assign bus.rd_data  = r_data;
    assign bus.rd_valid = r_valid;
    assign bus.bus_err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dm_load_unit.sv
//------------------------------------------------------------------------------
// Module  : tb_dm_load_unit
// Brief   : Directed bench for dm_load_unit (default timeout and ACK_TIMEOUT=4).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dm_load_unit;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    dm_load_unit_if ifa ();
    dm_load_unit_if ifb ();

    dm_load_unit #(.ACK_TIMEOUT(255)) u_dut_a (.clk(clk), .reset(reset), .bus(ifa.master));
    dm_load_unit #(.ACK_TIMEOUT(4))   u_dut_b (.clk(clk), .reset(reset), .bus(ifb.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One load on instance A: acks after 'waits' extra REQ cycles, then checks DONE and the IDLE after it.
    task automatic run_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] word, input int waits, input logic [31:0] exp);
        ifa.ld_valid  = 1'b1;
        ifa.ld_op     = op;
        ifa.ld_addr   = addr;
        ifa.mem_ack   = 1'b0;
        ifa.mem_rdata = 32'hDEAD0000;
        #1;
        chk({tag, ".stall_c0"}, 32'(ifa.ld_stall), 32'd1);
        chk({tag, ".misalign"}, 32'(ifa.misalign), 32'd0);
        chk({tag, ".req_c0"},   32'(ifa.mem_req),  32'd0);
        step();
        for (int i = 0; i <= waits; i++) begin
            chk({tag, ".req"},      32'(ifa.mem_req),  32'd1);
            chk({tag, ".mem_addr"}, ifa.mem_addr,      {addr[31:2], 2'b00});
            chk({tag, ".stall"},    32'(ifa.ld_stall), 32'd1);
            chk({tag, ".vld_early"},32'(ifa.rd_valid), 32'd0);
            if (i == waits) begin
                ifa.mem_ack   = 1'b1;
                ifa.mem_rdata = word;
            end
            step();
        end
        ifa.mem_ack   = 1'b0;
        ifa.ld_valid  = 1'b0;
        ifa.mem_rdata = 32'h13572468;
        #1;
        chk({tag, ".rd_valid"}, 32'(ifa.rd_valid), 32'd1);
        chk({tag, ".rd_data"},  ifa.rd_data,       exp);
        chk({tag, ".stall_dn"}, 32'(ifa.ld_stall), 32'd0);
        chk({tag, ".req_dn"},   32'(ifa.mem_req),  32'd0);
        chk({tag, ".bus_err"},  32'(ifa.bus_err),  32'd0);
        step();
        chk({tag, ".vld_1cyc"}, 32'(ifa.rd_valid), 32'd0);
        chk({tag, ".hold"},     ifa.rd_data,       exp);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        ifa.ld_valid = 1'b0; ifa.ld_addr = 32'd0; ifa.ld_op = 3'd0;
        ifa.mem_ack  = 1'b0; ifa.mem_rdata = 32'd0;
        ifb.ld_valid = 1'b0; ifb.ld_addr = 32'd0; ifb.ld_op = 3'd0;
        ifb.mem_ack  = 1'b0; ifb.mem_rdata = 32'd0;
        step();
        step();
        chk("rst.mem_req",  32'(ifa.mem_req),  32'd0);
        chk("rst.mem_addr", ifa.mem_addr,      32'd0);
        chk("rst.rd_data",  ifa.rd_data,       32'd0);
        chk("rst.rd_valid", 32'(ifa.rd_valid), 32'd0);
        chk("rst.bus_err",  32'(ifa.bus_err),  32'd0);
        chk("rst.stall",    32'(ifa.ld_stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Back-to-back loads, each accepted in the IDLE cycle after the previous DONE.
        run_load("lw100",  3'd0, 32'h0000_0100, 32'h8899AABB, 0, 32'h8899AABB);
        run_load("lb103",  3'd4, 32'h0000_0103, 32'h80AA55CC, 0, 32'hFFFFFF80);
        run_load("lbu103", 3'd3, 32'h0000_0103, 32'h80AA55CC, 0, 32'h00000080);
        run_load("lh102",  3'd2, 32'h0000_0102, 32'h80AA55CC, 0, 32'hFFFF80AA);
        run_load("lhu100", 3'd1, 32'h0000_0100, 32'h80AA55CC, 0, 32'h000055CC);
        run_load("lb102",  3'd4, 32'h0000_0102, 32'h80AA55CC, 1, 32'hFFFFFFAA);
        run_load("lh100",  3'd2, 32'h0000_0100, 32'h1234F00D, 0, 32'hFFFFF00D);
        run_load("lbu201", 3'd3, 32'h0000_0201, 32'h00007F00, 5, 32'h0000007F);
        run_load("op7",    3'd7, 32'h0000_0300, 32'hCAFEBABE, 2, 32'hCAFEBABE);

        // Misaligned loads: no request, no stall, no result.
        ifa.ld_valid = 1'b1; ifa.ld_op = 3'd0; ifa.ld_addr = 32'h0000_0102; #1;
        chk("mis_lw.misalign", 32'(ifa.misalign), 32'd1);
        chk("mis_lw.stall",    32'(ifa.ld_stall), 32'd0);
        step();
        chk("mis_lw.req",      32'(ifa.mem_req),  32'd0);
        chk("mis_lw.rd_valid", 32'(ifa.rd_valid), 32'd0);
        ifa.ld_op = 3'd2; ifa.ld_addr = 32'h0000_0101; #1;
        chk("mis_lh.misalign", 32'(ifa.misalign), 32'd1);
        chk("mis_lh.stall",    32'(ifa.ld_stall), 32'd0);
        step();
        chk("mis_lh.req",      32'(ifa.mem_req),  32'd0);
        chk("mis_lh.rd_valid", 32'(ifa.rd_valid), 32'd0);
        ifa.ld_valid = 1'b0; #1;
        chk("mis_off.misalign", 32'(ifa.misalign), 32'd0);
        step();

        // Timeout on instance B: a normal load first so rd_data=0 on timeout is meaningful.
        ifb.ld_valid = 1'b1; ifb.ld_op = 3'd0; ifb.ld_addr = 32'h0000_0040;
        step();
        ifb.mem_ack = 1'b1; ifb.mem_rdata = 32'hDEADBEEF;
        step();
        ifb.mem_ack = 1'b0; ifb.ld_valid = 1'b0; #1;
        chk("tob.pre_data", ifb.rd_data, 32'hDEADBEEF);
        step();
        ifb.ld_valid = 1'b1; ifb.ld_addr = 32'h0000_0044; #1;
        chk("to.stall_c0", 32'(ifb.ld_stall), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            step();
            chk("to.req",      32'(ifb.mem_req),  32'd1);
            chk("to.rd_valid", 32'(ifb.rd_valid), 32'd0);
        end
        step();
        ifb.ld_valid = 1'b0; #1;
        chk("to.rd_valid5", 32'(ifb.rd_valid), 32'd1);
        chk("to.bus_err",   32'(ifb.bus_err),  32'd1);
        chk("to.rd_data",   ifb.rd_data,       32'd0);
        chk("to.req_off",   32'(ifb.mem_req),  32'd0);
        step();
        chk("to.err_1cyc",  32'(ifb.bus_err),  32'd0);
        ifb.ld_valid = 1'b1; ifb.ld_addr = 32'h0000_0048;
        step();
        ifb.mem_ack = 1'b1; ifb.mem_rdata = 32'h0BADF00D;
        step();
        ifb.mem_ack = 1'b0; ifb.ld_valid = 1'b0; #1;
        chk("to_after.rd_valid", 32'(ifb.rd_valid), 32'd1);
        chk("to_after.bus_err",  32'(ifb.bus_err),  32'd0);
        chk("to_after.rd_data",  ifb.rd_data,       32'h0BADF00D);
        step();

        // Reset in the middle of REQ on instance A.
        ifa.ld_valid = 1'b1; ifa.ld_op = 3'd0; ifa.ld_addr = 32'h0000_0500;
        step();
        step();
        chk("rstreq.req_before", 32'(ifa.mem_req), 32'd1);
        reset = 1'b1; ifa.ld_valid = 1'b0; #1;
        chk("rstreq.req",      32'(ifa.mem_req),  32'd0);
        chk("rstreq.mem_addr", ifa.mem_addr,      32'd0);
        chk("rstreq.rd_data",  ifa.rd_data,       32'd0);
        chk("rstreq.rd_valid", 32'(ifa.rd_valid), 32'd0);
        chk("rstreq.stall",    32'(ifa.ld_stall), 32'd0);
        step();
        @(negedge clk);
        reset = 1'b0;
        step();
        run_load("post_rst", 3'd0, 32'h0000_0600, 32'h55AA33CC, 1, 32'h55AA33CC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
